// File: rtl/bp_update_ctrl_pkg.sv
// Shared constants, counter/state encodings and counter helper for the branch-predictor update path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bp_update_ctrl_pkg;

    localparam int          WORD_SIZE          = 16;
    localparam int          BTB_INDEX_W        = 8;
    localparam int          BTB_TAG_W          = 8;
    localparam int          BP_FIFO_DEPTH      = 4;
    localparam logic [15:0] BTB_INVALID_TARGET = 16'hFFFF;

    // Global 2-bit saturating branch counter encodings
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_NT  = 2'b01,
        CTR_T   = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    // Update controller FSM encodings
    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } bp_state_t;

    // Saturating step of the global counter toward the observed outcome
    function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
        if (taken) begin
            return (cur == CTR_ST) ? cur : cur + 2'd1;
        end
        return (cur == CTR_SNT) ? cur : cur - 2'd1;
    endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Bundle between branch-resolve stage, update controller and the BTB/counter consumers.
// Latency: n/a (wires only).
// Backpressure: none; resolve reports are fire-and-forget, overflow is counted by the controller.
interface bp_update_ctrl_if
    import bp_update_ctrl_pkg::*;
#(
    parameter int WORD_W  = WORD_SIZE,
    parameter int INDEX_W = BTB_INDEX_W,
    parameter int TAG_W   = BTB_TAG_W
);
    logic               resolve_valid;
    logic [WORD_W-1:0]  resolve_pc;
    logic [WORD_W-1:0]  resolve_target;
    logic               resolve_taken;
    logic               flush_req;
    logic               btb_we;
    logic [INDEX_W-1:0] btb_index;
    logic [TAG_W-1:0]   btb_wtag;
    logic [WORD_W-1:0]  btb_wtarget;
    logic [1:0]         ctr_state;
    logic               busy;
    logic [7:0]         drop_count;

    // Resolve stage side: issues reports and flushes, observes predictor writes
    modport master (
        output resolve_valid, resolve_pc, resolve_target, resolve_taken, flush_req,
        input  btb_we, btb_index, btb_wtag, btb_wtarget, ctr_state, busy, drop_count
    );

    // Update controller side
    modport slave (
        input  resolve_valid, resolve_pc, resolve_target, resolve_taken, flush_req,
        output btb_we, btb_index, btb_wtag, btb_wtarget, ctr_state, busy, drop_count
    );
endinterface

// File: rtl/bp_update_fifo.sv
// Small synchronous FIFO holding pending BTB updates; head is visible combinationally on dout.
// Latency: a pushed entry is poppable on the cycle after the push edge.
// Backpressure: full refuses a lone push, but push+pop on a full FIFO succeeds; pop on empty is ignored.
module bp_update_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    // Qualify requests: a pop on a full FIFO frees the slot used by a same-edge push
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage array: no reset needed, occupancy tracks validity
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; clear drops everything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/bp_update_ctrl.sv
// Sequences BTB writes (post-reset/flush invalidation sweep, then queued taken-branch updates) and the global counter.
// Latency: taken resolve at edge N appears as a BTB write after edge N+1 when idle in RUN; sweep is 2**INDEX_W cycles.
// Backpressure: none upstream; taken resolves arriving with the queue full are dropped and counted in drop_count.
module bp_update_ctrl
    import bp_update_ctrl_pkg::*;
#(
    parameter int               WORD_W         = WORD_SIZE,
    parameter int               INDEX_W        = BTB_INDEX_W,
    parameter int               TAG_W          = BTB_TAG_W,
    parameter int               FIFO_DEPTH     = BP_FIFO_DEPTH,
    parameter logic [WORD_W-1:0] INVALID_TARGET = BTB_INVALID_TARGET
) (
    input  logic             clk,
    input  logic             reset,
    bp_update_ctrl_if.slave  bus
);
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] target;
    } entry_t;

    bp_state_t          state;
    logic [INDEX_W-1:0] sweep_idx;
    entry_t             push_dat;
    entry_t             head_dat;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               drop;
    logic               taken_rpt;

    // Queue control: flush swallows any same-cycle resolve; sweep blocks draining
    always_comb begin
        taken_rpt = bus.resolve_valid && bus.resolve_taken && !bus.flush_req;
        pop       = (state == ST_RUN) && !fifo_empty && !bus.flush_req;
        push      = taken_rpt && (!fifo_full || pop);
        drop      = taken_rpt && fifo_full && !pop;
        push_dat  = '{pc: bus.resolve_pc, target: bus.resolve_target};
    end

    bp_update_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WORD_W     ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.flush_req),
        .push  (push),
        .pop   (pop),
        .din   (push_dat),
        .dout  (head_dat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sweep/run FSM with registered BTB write port and busy flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_SWEEP;
            sweep_idx       <= '0;
            bus.btb_we      <= 1'b0;
            bus.btb_index   <= '0;
            bus.btb_wtag    <= '0;
            bus.btb_wtarget <= INVALID_TARGET;
            bus.busy        <= 1'b1;
        end else if (bus.flush_req) begin
            state      <= ST_SWEEP;
            sweep_idx  <= '0;
            bus.btb_we <= 1'b0;
            bus.busy   <= 1'b1;
        end else begin
            case (state)
                ST_SWEEP: begin
                    bus.btb_we      <= 1'b1;
                    bus.btb_index   <= sweep_idx;
                    bus.btb_wtag    <= '0;
                    bus.btb_wtarget <= INVALID_TARGET;
                    sweep_idx       <= sweep_idx + 1'b1;
                    if (sweep_idx == '1) begin
                        state    <= ST_RUN;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    bus.btb_we <= pop;
                    if (pop) begin
                        bus.btb_index   <= head_dat.pc[INDEX_W-1:0];
                        bus.btb_wtag    <= head_dat.pc[INDEX_W+TAG_W-1:INDEX_W];
                        bus.btb_wtarget <= head_dat.target;
                    end
                end
            endcase
        end
    end

    // Global counter follows every accepted resolve, in any state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ctr_state <= CTR_SNT;
        end else if (bus.flush_req) begin
            bus.ctr_state <= CTR_SNT;
        end else if (bus.resolve_valid) begin
            bus.ctr_state <= ctr_next(bus.ctr_state, bus.resolve_taken);
        end
    end

    // Overflow counter survives flushes, saturates at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.drop_count <= '0;
        end else if (drop && (bus.drop_count != 8'hFF)) begin
            bus.drop_count <= bus.drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_bp_update_ctrl.sv
// Bench for bp_update_ctrl: directed table, corner sequences, randomized run against a queue-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bp_update_ctrl;
    import bp_update_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;

    bp_update_ctrl_if bus ();

    bp_update_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: sweep position, queue of pending updates, plain integer counters
    typedef struct {
        logic [15:0] pc;
        logic [15:0] tgt;
    } ent_t;

    ent_t        q[$];
    bit          m_sweeping;
    int          m_pos;
    int          m_ctr;
    int          m_drop;
    logic        m_we;
    logic [7:0]  m_idx;
    logic [7:0]  m_tag;
    logic [15:0] m_tgt;

    function automatic void model_reset();
        m_sweeping = 1'b1;
        m_pos      = 0;
        q.delete();
        m_ctr  = 0;
        m_drop = 0;
        m_we   = 1'b0;
        m_idx  = 8'h00;
        m_tag  = 8'h00;
        m_tgt  = 16'hFFFF;
    endfunction

    // Advance the model by one clock edge using the inputs presented for that edge
    function automatic void model_step();
        ent_t e;
        if (bus.flush_req) begin
            m_sweeping = 1'b1;
            m_pos      = 0;
            q.delete();
            m_ctr = 0;
            m_we  = 1'b0;
            return;
        end
        if (m_sweeping) begin
            m_we  = 1'b1;
            m_idx = m_pos[7:0];
            m_tag = 8'h00;
            m_tgt = 16'hFFFF;
            m_pos = m_pos + 1;
            if (m_pos == 256) m_sweeping = 1'b0;
        end else if (q.size() > 0) begin
            e     = q.pop_front();
            m_we  = 1'b1;
            m_idx = e.pc[7:0];
            m_tag = e.pc[15:8];
            m_tgt = e.tgt;
        end else begin
            m_we = 1'b0;
        end
        if (bus.resolve_valid && bus.resolve_taken) begin
            if (q.size() < 4) begin
                e.pc  = bus.resolve_pc;
                e.tgt = bus.resolve_target;
                q.push_back(e);
            end else if (m_drop < 255) begin
                m_drop = m_drop + 1;
            end
        end
        if (bus.resolve_valid) begin
            if (bus.resolve_taken) m_ctr = (m_ctr < 3) ? m_ctr + 1 : 3;
            else                   m_ctr = (m_ctr > 0) ? m_ctr - 1 : 0;
        end
    endfunction

    task automatic check_all(input string name);
        logic ok;
        ok = (bus.btb_we == m_we) && (bus.btb_index == m_idx) && (bus.btb_wtag == m_tag) &&
             (bus.btb_wtarget == m_tgt) && (bus.ctr_state == m_ctr[1:0]) &&
             (bus.busy == m_sweeping) && (bus.drop_count == m_drop[7:0]);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s t=%0t: dut we=%0b idx=%h tag=%h tgt=%h ctr=%0d busy=%0b drop=%0d, model we=%0b idx=%h tag=%h tgt=%h ctr=%0d busy=%0b drop=%0d",
                     name, $time, bus.btb_we, bus.btb_index, bus.btb_wtag, bus.btb_wtarget, bus.ctr_state,
                     bus.busy, bus.drop_count, m_we, m_idx, m_tag, m_tgt, m_ctr, m_sweeping, m_drop);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] tgt,
                         input logic tk, input logic fl);
        bus.resolve_valid  = v;
        bus.resolve_pc     = pc;
        bus.resolve_target = tgt;
        bus.resolve_taken  = tk;
        bus.flush_req      = fl;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    // One edge: sample at the following falling edge, step the model, compare
    task automatic tick(input string name);
        @(negedge clk);
        model_step();
        check_all(name);
    endtask

    // Count cycles with busy high, stepping the bench; bounded
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!bus.busy) break;
            n++;
            tick("sweep");
        end
    endtask

    typedef struct {
        logic        v;
        logic        tk;
        logic        fl;
        logic [15:0] pc;
        logic [15:0] tgt;
        logic        ewe;
        logic [7:0]  eidx;
        logic [7:0]  etag;
        logic [15:0] etgt;
        logic [1:0]  ectr;
    } row_t;

    row_t tbl[11];

    initial begin
        int nb;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h3A12, 16'h3A40, 1'b0, 8'hFF, 8'h00, 16'hFFFF, 2'd1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h12, 8'h3A, 16'h3A40, 2'd1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0009, 1'b0, 8'h12, 8'h3A, 16'h3A40, 2'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h12, 8'h3A, 16'h3A40, 2'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'h1101, 16'h2001, 1'b0, 8'h12, 8'h3A, 16'h3A40, 2'd1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'h1202, 16'h2002, 1'b1, 8'h01, 8'h11, 16'h2001, 2'd2};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h1303, 16'h2003, 1'b1, 8'h02, 8'h12, 16'h2002, 2'd3};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h1404, 16'h2004, 1'b1, 8'h03, 8'h13, 16'h2003, 2'd3};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 16'h1505, 16'h2005, 1'b1, 8'h04, 8'h14, 16'h2004, 2'd3};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0077, 16'h0000, 1'b1, 8'h05, 8'h15, 16'h2005, 2'd2};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h05, 8'h15, 16'h2005, 2'd2};

        // Reset values
        reset = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        chk("reset_tgt", 32'(bus.btb_wtarget), 32'hFFFF);
        chk("reset_busy", 32'(bus.busy), 32'd1);

        // Power-up sweep: busy for exactly 256 cycles, writes 0..255
        reset = 1'b0;
        count_busy(nb);
        chk("busy_cycles", 32'(nb), 32'd256);
        chk("last_sweep_idx", 32'(bus.btb_index), 32'hFF);
        tick("post_sweep");
        chk("post_sweep_we", 32'(bus.btb_we), 32'd0);

        // Directed RUN-mode table
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].pc, tbl[i].tgt, tbl[i].tk, tbl[i].fl);
            tick($sformatf("tbl%0d_model", i));
            chk($sformatf("tbl%0d_we", i),  32'(bus.btb_we),      32'(tbl[i].ewe));
            chk($sformatf("tbl%0d_idx", i), 32'(bus.btb_index),   32'(tbl[i].eidx));
            chk($sformatf("tbl%0d_tag", i), 32'(bus.btb_wtag),    32'(tbl[i].etag));
            chk($sformatf("tbl%0d_tgt", i), 32'(bus.btb_wtarget), 32'(tbl[i].etgt));
            chk($sformatf("tbl%0d_ctr", i), 32'(bus.ctr_state),   32'(tbl[i].ectr));
        end
        idle();
        tick("tbl_idle");

        // Six takens during a sweep: four queued, two dropped, drained in order after the sweep
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tick("flush1");
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, {8'(8'h50 + k), 8'(8'h10 + k)}, 16'(16'h6000 + k), 1'b1, 1'b0);
            tick("sweep_push");
        end
        idle();
        chk("sweep_drop", 32'(bus.drop_count), 32'd2);
        chk("sweep_ctr", 32'(bus.ctr_state), 32'd3);
        count_busy(nb);
        chk("sweep_busy_total", 32'(nb), 32'd250);
        for (int k = 0; k < 4; k++) begin
            tick("drain");
            chk($sformatf("drain%0d_we", k),  32'(bus.btb_we),      32'd1);
            chk($sformatf("drain%0d_idx", k), 32'(bus.btb_index),   32'(8'h10 + k));
            chk($sformatf("drain%0d_tag", k), 32'(bus.btb_wtag),    32'(8'h50 + k));
            chk($sformatf("drain%0d_tgt", k), 32'(bus.btb_wtarget), 32'(16'h6000 + k));
        end
        tick("drain_done");
        chk("drain_done_we", 32'(bus.btb_we), 32'd0);

        // Flush with a same-cycle taken resolve while three entries are queued
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tick("flush2");
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'(16'h7000 + k), 16'(16'h7100 + k), 1'b1, 1'b0);
            tick("q3");
        end
        idle();
        tick("q3_idle");
        drive(1'b1, 16'h7777, 16'h7778, 1'b1, 1'b1);
        tick("flush_resolve");
        idle();
        chk("flush_ctr", 32'(bus.ctr_state), 32'd0);
        chk("flush_drop", 32'(bus.drop_count), 32'd2);
        chk("flush_busy", 32'(bus.busy), 32'd1);
        chk("flush_we", 32'(bus.btb_we), 32'd0);
        tick("restart0");
        chk("restart_idx0", 32'(bus.btb_index), 32'd0);
        chk("restart_we", 32'(bus.btb_we), 32'd1);
        count_busy(nb);
        for (int k = 0; k < 3; k++) begin
            tick("flushed_quiet");
            chk("flushed_no_write", 32'(bus.btb_we), 32'd0);
        end

        // Asynchronous reset in the middle of a sweep
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tick("flush3");
        idle();
        for (int k = 0; k < 101; k++) tick("to_idx100");
        chk("at_idx100", 32'(bus.btb_index), 32'd100);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_we",   32'(bus.btb_we),      32'd0);
        chk("arst_idx",  32'(bus.btb_index),   32'd0);
        chk("arst_tgt",  32'(bus.btb_wtarget), 32'hFFFF);
        chk("arst_busy", 32'(bus.busy),        32'd1);
        chk("arst_drop", 32'(bus.drop_count),  32'd0);
        model_reset();
        @(negedge clk);
        check_all("in_reset");
        reset = 1'b0;
        count_busy(nb);
        chk("rst_busy_cycles", 32'(nb), 32'd256);

        // Overflow saturation and full-FIFO push+pop in RUN
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tick("flush4");
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
            tick("flood");
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tick("flush5");
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
            tick("flood2");
        end
        idle();
        chk("drop_sat", 32'(bus.drop_count), 32'd255);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom % 3) == 0, 16'($urandom), 16'($urandom), 1'($urandom),
                  ($urandom % 400) == 0);
            tick("random");
        end
        idle();
        tick("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
Sequences all writes into the branch predictor: the BTB write port and the global 2-bit saturating counter. It accepts resolved-branch reports from the branch-resolve stage and buffers them in a small FIFO. It also runs a table-initialization sweep after reset and on a flush request. While a sweep is active it raises busy, and the predictor then returns PC+1.

Parameters:
WORD_W, 16, PC/target width (WORD_SIZE)
INDEX_W, 8, BTB index width (PC[7:0]); table depth 2**INDEX_W
TAG_W, 8, BTB tag width (PC[15:8])
FIFO_DEPTH, 4, pending BTB-update entries (power of 2)
INVALID_TARGET, 16'hFFFF, target value marking an empty entry

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
resolve_valid  in  1  one-cycle pulse: a conditional branch resolved this cycle
resolve_pc  in  WORD_W  PC of the resolved branch
resolve_target  in  WORD_W  computed taken target (PC+Imm)
resolve_taken  in  1  actual branch outcome
flush_req  in  1  one-cycle pulse: invalidate the whole BTB
btb_we  out  1  BTB write strobe
btb_index  out  INDEX_W  entry being written
btb_wtag  out  TAG_W  tag to write
btb_wtarget  out  WORD_W  target to write
ctr_state  out  2  global counter: 00 strongly NT, 01 NT, 10 T, 11 strongly T
busy  out  1  sweep in progress; predictor must not use the BTB
drop_count  out  8  saturating count of updates lost to FIFO overflow

Behaviour:
- All outputs are registered.
- Reset values: btb_we=0, btb_index=0, btb_wtag=0, btb_wtarget=INVALID_TARGET, ctr_state=00, busy=1, drop_count=0, FIFO empty, state=SWEEP, sweep_idx=0.
- FSM states are SWEEP and RUN.
- SWEEP:
  - Each cycle: btb_we=1, btb_index=sweep_idx, btb_wtag=0, btb_wtarget=INVALID_TARGET.
  - sweep_idx increments each cycle. The sweep covers exactly 2**INDEX_W cycles (256).
  - After writing index 255, the next state is RUN and busy=0 from that cycle onward.
- RUN:
  - If the FIFO is non-empty, pop one entry per cycle. Next cycle: btb_we=1, index=pc[7:0], tag=pc[15:8], target=entry target.
  - If the FIFO is empty: btb_we=0. btb_index, btb_wtag and btb_wtarget hold their previous values.
- Enqueue rule: a resolve with resolve_taken=1 pushes {pc, target}. A not-taken resolve never touches the BTB.
- Enqueue is allowed in either state. Sweep writes always take priority over FIFO drain.
- Latency: with the FIFO empty in RUN, a taken resolve sampled at edge N produces btb_we=1 in the cycle after edge N+1 (2 edges).
- FIFO full with a new taken resolve: the entry is dropped and drop_count increments, saturating at 255.
- Simultaneous pop and push when full: the push succeeds (a slot frees the same edge).
- Global counter:
  - On every resolve_valid, ctr_state updates at the next edge.
  - Taken: +1, saturating at 11. Not-taken: -1, saturating at 00.
  - Updates happen in every state, including SWEEP.
- flush_req, sampled in either state:
  - next state=SWEEP, sweep_idx=0, FIFO cleared, ctr_state=00, busy=1.
  - A resolve in the same cycle as flush_req is discarded: no enqueue, no counter change, no drop_count increment.
  - flush_req during SWEEP restarts the sweep from index 0.
- Reset asserted mid-operation returns all state to the reset values immediately (asynchronous) and restarts the sweep from 0.
- Index 0 written by the sweep and by an update are indistinguishable at the port. The bench must rely on state/busy, not on the value.

Decomposition:
- Shared package/include (alongside opcodes.v): WORD_SIZE, BTB_INDEX_W, BTB_TAG_W, BTB_INVALID_TARGET, the 2-bit counter encodings (SNT/NT/T/ST), and the FSM state encodings.
- One natural sub-module: bp_update_fifo. It is a synchronous FIFO with parameters FIFO_DEPTH/WORD_W and ports push, pop, din, dout, full, empty. Simultaneous push+pop is legal when full.
- The FSM, counter and sweep logic stay in the top level.

Test Plan:
- Reset release -> busy=1 for exactly 256 cycles. btb_we=1 with index 0..255 ascending, tag 0, target FFFF. Then busy=0 and btb_we=0.
- In RUN, resolve pc=16'h3A12, target=16'h3A40, taken=1 -> two edges later: btb_we=1, index=8'h12, tag=8'h3A, target=16'h3A40, ctr_state 00->01.
- Resolve taken=0 with pc=16'h0005 -> no btb_we. Repeated taken x5 then not-taken x1 -> ctr_state is 11 after three takens, stays 11, then 10.
- During the sweep, 6 taken resolves -> 4 queued, drop_count=2. The 4 writes appear in order immediately after the sweep ends.
- Three entries queued, then flush_req together with a taken resolve -> FIFO emptied, resolve ignored, ctr_state=00, sweep restarts at index 0, drop_count unchanged.
- Reset asserted at sweep index 100 -> outputs return to reset values asynchronously. After release the sweep restarts at index 0 and runs 256 cycles.
